// File: rtl/ammo_loader_if.sv
// Command/supply and weapons-side signal bundle for the ammo reload sequencer.
// Latency: none, wires only.
// Backpressure: none; busy tells the requester when requests will be dropped.
interface ammo_loader_if #(
    parameter int N  = 9,
    parameter int RW = 12
);
    logic          reload_req;
    logic          fire;
    logic [N-1:0]  cur_ammo;
    logic          restock;
    logic [RW-1:0] restock_amt;
    logic [N-1:0]  ammo;
    logic          loadingAmmo;
    logic          busy;
    logic [RW-1:0] reserve;
    logic          error;

    modport master (
        output reload_req, fire, cur_ammo, restock, restock_amt,
        input  ammo, loadingAmmo, busy, reserve, error
    );

    modport slave (
        input  reload_req, fire, cur_ammo, restock, restock_amt,
        output ammo, loadingAmmo, busy, reserve, error
    );
endinterface

// File: rtl/ammo_loader.sv
// Magazine reload sequencer: waits out fire, delays, then strobes the new magazine count.
// Latency: accepted request to loadingAmmo strobe is RELOAD_CYCLES+1 cycles.
// Backpressure: reload requests are dropped while busy; restock is accepted every cycle.
module ammo_loader #(
    parameter int N             = 9,
    parameter int RW            = 12,
    parameter int MAG_MAX       = 300,
    parameter int RELOAD_CYCLES = 8,
    parameter int RESERVE_INIT  = 1000
) (
    input  logic          clk,
    input  logic          rst,
    ammo_loader_if.slave  io
);
    localparam int             CW       = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
    localparam int             WW       = ((N > RW) ? N : RW) + 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(RELOAD_CYCLES - 1);
    localparam logic [N:0]     MAG      = (N+1)'(MAG_MAX);
    localparam logic [RW:0]    RES_MAX  = {1'b0, {RW{1'b1}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FIRE = 2'd1,
        RELOAD    = 2'd2,
        LOAD      = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  xfer_q, xfer_d;
    logic [N-1:0]  ammo_q, ammo_d;
    logic [RW-1:0] reserve_q, reserve_d;
    logic          load_q, busy_q, error_q, error_d;

    logic [N:0]    need;
    logic [WW-1:0] need_w, res_w;
    logic [N-1:0]  xfer_calc;
    logic [N:0]    ammo_sum;
    logic [N-1:0]  ammo_new;
    logic          go_check;
    logic          load_edge;
    logic [RW:0]   res_base, res_sum;

    // Start-check arithmetic: shortfall to a full magazine, limited by stock on hand.
    always_comb begin
        need      = ({1'b0, io.cur_ammo} >= MAG) ? '0 : (MAG - {1'b0, io.cur_ammo});
        need_w    = WW'(need);
        res_w     = WW'(reserve_q);
        xfer_calc = N'((need_w < res_w) ? need_w : res_w);
    end

    // cur_ammo is re-read at LOAD entry so shots during RELOAD are not refilled twice.
    always_comb begin
        ammo_sum = {1'b0, io.cur_ammo} + {1'b0, xfer_q};
        ammo_new = N'((ammo_sum > MAG) ? MAG : ammo_sum);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xfer_d   = xfer_q;
        ammo_d   = ammo_q;
        error_d  = 1'b0;
        go_check = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.reload_req) begin
                    if (io.fire) state_d  = WAIT_FIRE;
                    else         go_check = 1'b1;
                end
            end
            WAIT_FIRE: begin
                if (!io.fire) go_check = 1'b1;
            end
            RELOAD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = LOAD;
                    ammo_d  = ammo_new;
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (go_check) begin
            if (xfer_calc == '0) begin
                state_d = IDLE;
                error_d = 1'b1;
            end else begin
                xfer_d  = xfer_calc;
                cnt_d   = CNT_LOAD;
                state_d = RELOAD;
            end
        end
    end

    // Decrement before the saturating restock so a coincident restock is never lost.
    always_comb begin
        load_edge = (state_q == RELOAD) && (cnt_q == '0);
        res_base  = load_edge ? ({1'b0, reserve_q} - (RW+1)'(xfer_q)) : {1'b0, reserve_q};
        res_sum   = res_base + (io.restock ? {1'b0, io.restock_amt} : '0);
        reserve_d = (res_sum > RES_MAX) ? RES_MAX[RW-1:0] : res_sum[RW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            xfer_q    <= '0;
            ammo_q    <= '0;
            reserve_q <= RW'(RESERVE_INIT);
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            xfer_q    <= xfer_d;
            ammo_q    <= ammo_d;
            reserve_q <= reserve_d;
            load_q    <= (state_d == LOAD);
            busy_q    <= (state_d != IDLE);
            error_q   <= error_d;
        end
    end

    assign io.ammo        = ammo_q;
    assign io.loadingAmmo = load_q;
    assign io.busy        = busy_q;
    assign io.reserve     = reserve_q;
    assign io.error       = error_q;
endmodule

// File: tb/tb_ammo_loader.sv
// Directed and randomized reload transactions checked against a transaction-level model.
// Latency: strobe expected RELOAD_CYCLES edges after the accepting edge.
// Backpressure: requests while busy are expected to be dropped.
module tb_ammo_loader;
    localparam int N   = 9;
    localparam int RW  = 12;
    localparam int MAG = 300;
    localparam int RC  = 8;
    localparam int RINIT = 1000;
    localparam int RSAT  = 4095;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_res = RINIT;

    ammo_loader_if #(.N(N), .RW(RW)) bus ();

    ammo_loader #(
        .N(N), .RW(RW), .MAG_MAX(MAG), .RELOAD_CYCLES(RC), .RESERVE_INIT(RINIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic restock_idle(input int amt);
        bus.restock     = 1'b1;
        bus.restock_amt = RW'(amt);
        tick();
        bus.restock = 1'b0;
        m_res = imin(m_res + amt, RSAT);
        check("restock_reserve", bus.reserve, m_res);
    endtask

    // One reload attempt: cur0 at the accepting edge, cur1 at the LOAD-entry edge.
    task automatic run_reload(input int cur0, input int cur1, input int f_len,
                              input bit rs_load, input int rs_amt, input bit extra_req);
        int need, xfer, exp_ammo;
        need = (cur0 >= MAG) ? 0 : MAG - cur0;
        xfer = imin(need, m_res);
        bus.cur_ammo   = N'(cur0);
        bus.reload_req = 1'b1;
        bus.fire       = (f_len > 0);
        tick();
        bus.reload_req = 1'b0;
        if (f_len > 0) begin
            for (int i = 1; i < f_len; i++) begin
                check("wait_fire_busy", bus.busy, 1);
                check("wait_fire_nostrobe", bus.loadingAmmo, 0);
                tick();
            end
            check("wait_fire_busy", bus.busy, 1);
            bus.fire = 1'b0;
            tick();
        end
        if (xfer == 0) begin
            check("reject_error", bus.error, 1);
            check("reject_busy", bus.busy, 0);
            check("reject_reserve", bus.reserve, m_res);
            tick();
            check("reject_error_pulse", bus.error, 0);
            for (int i = 0; i <= RC; i++) begin
                check("reject_nostrobe", bus.loadingAmmo, 0);
                tick();
            end
            return;
        end
        check("accept_busy", bus.busy, 1);
        check("accept_noerror", bus.error, 0);
        bus.cur_ammo = N'(cur1);
        for (int i = 1; i <= RC; i++) begin
            if (extra_req) bus.reload_req = (i == 2);
            bus.fire = 1'($urandom_range(0, 1));
            if (i == RC && rs_load) begin
                bus.restock     = 1'b1;
                bus.restock_amt = RW'(rs_amt);
            end
            check("reload_nostrobe", bus.loadingAmmo, 0);
            check("reload_busy", bus.busy, 1);
            tick();
        end
        bus.restock    = 1'b0;
        bus.fire       = 1'b0;
        bus.reload_req = 1'b0;
        m_res = m_res - xfer;
        if (rs_load) m_res = imin(m_res + rs_amt, RSAT);
        exp_ammo = imin(cur1 + xfer, MAG);
        check("load_strobe", bus.loadingAmmo, 1);
        check("load_ammo", bus.ammo, exp_ammo);
        check("load_reserve", bus.reserve, m_res);
        check("load_busy", bus.busy, 1);
        tick();
        check("post_strobe", bus.loadingAmmo, 0);
        check("post_busy", bus.busy, 0);
        check("post_ammo_hold", bus.ammo, exp_ammo);
        if (extra_req) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check("dropped_req_nostrobe", bus.loadingAmmo, 0);
                check("dropped_req_idle", bus.busy, 0);
            end
        end
    endtask

    initial begin
        bus.reload_req  = 1'b0;
        bus.fire        = 1'b0;
        bus.cur_ammo    = '0;
        bus.restock     = 1'b0;
        bus.restock_amt = '0;
        rst = 1'b0;
        tick();
        tick();
        check("rst_ammo", bus.ammo, 0);
        check("rst_strobe", bus.loadingAmmo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_error", bus.error, 0);
        check("rst_reserve", bus.reserve, RINIT);
        #2 rst = 1'b1;
        tick();

        // basic reload: 1000 -> 800
        run_reload(100, 100, 0, 1'b0, 0, 1'b0);
        // fire hold-off for 5 cycles plus a dropped request during RELOAD
        run_reload(150, 150, 5, 1'b0, 0, 1'b1);
        // shots during RELOAD: xfer 200, ammo 290
        run_reload(100, 90, 0, 1'b0, 0, 1'b0);
        // restock coinciding with LOAD entry: 1000 - 200 + 100
        restock_idle(1000 - m_res);
        run_reload(100, 100, 0, 1'b1, 100, 1'b0);
        // drain to a reserve-limited reload
        run_reload(0, 0, 0, 1'b0, 0, 1'b0);
        run_reload(0, 0, 0, 1'b0, 0, 1'b0);
        run_reload(50, 50, 0, 1'b0, 0, 1'b0);
        check("limited_pre_reserve", bus.reserve, 50);
        run_reload(0, 0, 0, 1'b0, 0, 1'b0);
        check("limited_reserve_zero", bus.reserve, 0);
        run_reload(0, 0, 0, 1'b0, 0, 1'b0);
        run_reload(0, 0, 3, 1'b0, 0, 1'b0);
        restock_idle(100);
        run_reload(300, 300, 0, 1'b0, 0, 1'b0);
        run_reload(400, 400, 0, 1'b0, 0, 1'b0);
        // saturation
        restock_idle(4000 - m_res);
        restock_idle(500);
        check("sat_reserve", bus.reserve, RSAT);

        // asynchronous reset while RELOAD counter is 3
        restock_idle(0);
        bus.cur_ammo   = N'(100);
        bus.reload_req = 1'b1;
        tick();
        bus.reload_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_busy", bus.busy, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_reserve", bus.reserve, RINIT);
        check("async_rst_strobe", bus.loadingAmmo, 0);
        check("async_rst_ammo", bus.ammo, 0);
        tick();
        #2 rst = 1'b1;
        m_res = RINIT;
        for (int i = 0; i < RC + 4; i++) begin
            tick();
            check("post_rst_nostrobe", bus.loadingAmmo, 0);
        end
        check("post_rst_reserve", bus.reserve, RINIT);

        // randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            int c0, c1;
            c0 = (t % 5 == 0) ? int'($urandom_range(290, 511)) : int'($urandom_range(0, 320));
            c1 = c0 - int'($urandom_range(0, imin(c0, 20)));
            if ($urandom_range(0, 3) == 0) restock_idle(int'($urandom_range(0, 700)));
            run_reload(c0, c1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 400)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
